ps2_rx_events: RTL
==================

Name: ps2_rx_events

Overview:
- Parametrised PS/2 keyboard receiver that succeeds the fixed 8-entry keyboard front end.
- Samples the raw ps2_clk/ps2_data pins, deframes 11-bit frames and validates start, parity and stop bits.
- Folds E0/F0 prefixes into flags on each event and buffers events in a FIFO of configurable depth.
- Feeds the key/segment display logic and any CPU-side MMIO reader through a valid/ready pop port, with error reporting and frame timeout recovery.

Parameters:
- FIFO_DEPTH, 8: number of event entries; power of 2, at least 2.
- SYNC_STAGES, 3: synchroniser flops on ps2_clk and ps2_data; at least 2.
- TIMEOUT_CYCLES, 5000: number of clk cycles without a ps2_clk falling edge, mid-frame, before the frame is aborted.

Ports:
- clk  in  1: system clock.
- clr  in  1: reset, synchronous, active-high.
- ps2_clk  in  1: raw PS/2 clock pin, asynchronous.
- ps2_data  in  1: raw PS/2 data pin, asynchronous.
- ev_valid  out  1: the FIFO is non-empty.
- ev_ready  in  1: consumer pops the head entry when ev_valid && ev_ready.
- ev_data  out  10: head event, {ext, brk, scan[7:0]}.
- level  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- overflow  out  1: sticky flag; an event was dropped because the FIFO was full.
- ovf_clr  in  1: clears overflow.
- err_parity  out  1: one-cycle pulse on a frame with bad parity, stop bit or start bit.
- err_frame  out  1: one-cycle pulse when a frame times out.
- err_count  out  8: saturating count of parity and frame errors.

Behaviour:
- Reset values (clr=1 at a clk edge): ev_valid=0, level=0, overflow=0, err_parity=0, err_frame=0, err_count=0.
- Reset also clears the bit counter, the ext/brk pending flags and the timeout counter.
- Reset overrides every other event in the same cycle, including mid-frame; any partial frame is discarded.
- Synchronisation: both pins pass through SYNC_STAGES flops. A sample strobe fires on the cycle the synchronised ps2_clk goes 1->0, and ps2_data is taken from the same synchroniser depth.
- Frame receive: a bit counter runs 0..10 and captures one bit per strobe.
  - Bit 0 (start) must be 0. If it is 1, the receiver stays idle, the counter stays 0 and no error is raised (this provides line resync).
  - On bit 10, the frame is valid iff start=0, stop=1 and XOR(data[7:0], parity)=1 (odd parity).
  - An invalid frame pulses err_parity and produces no event.
- Timeout: while the bit counter is non-zero, count clk cycles since the last strobe. On reaching TIMEOUT_CYCLES, reset the counter to 0, pulse err_frame and clear the pending flags.
- Decode of a valid byte:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte issues a push of {ext_pend, brk_pend, byte}, then clears both pending flags.
  - A sequence such as E0 F0 75 yields one event, 0x375.
- FIFO: ring buffer with pointer width $clog2(FIFO_DEPTH); pointers wrap naturally. ev_data is combinationally the head entry and is undefined when ev_valid=0.
- Pop and push occur on the same edge. A push is accepted if level<FIFO_DEPTH or a pop happens in that cycle; simultaneous push and pop while full is accepted, level is unchanged and no overflow is set.
- A push while full with no pop drops the event and sets overflow; the pending flags are still cleared.
- ovf_clr=1 clears overflow. If a new overflow occurs in the same cycle, set wins.
- Latency: ev_valid rises exactly SYNC_STAGES+2 clk cycles after the pin-level ps2_clk falling edge of the stop bit, given an empty FIFO. The verifier checks this exact count.
- err_count increments by 1 on each err_parity or err_frame pulse and holds at 255. The two pulses cannot coincide.
- ev_ready while ev_valid=0 is ignored.

Decomposition:
- Package ps2_pkg holds:
  - constants SCAN_EXT=8'hE0 and SCAN_BRK=8'hF0;
  - event field indices EV_EXT=9, EV_BRK=8, EV_SCAN=7:0;
  - event width EV_W=10.
- Sub-module ps2_frame_rx contains the synchroniser, edge detect, shift register, parity/stop check and timeout. It outputs byte_valid, byte[7:0], err_parity and err_frame.
- The top level holds the prefix decoder, the FIFO and the error counter.

Test Plan:
- Frame 0x1C, bits LSB first with parity=0 -> ev_data=0x01C, level=1; pulse ev_ready -> ev_valid=0, level=0.
- Frames F0,1C then E0,F0,75 -> two events in order, 0x11C then 0x375; no event is produced for the prefix bytes.
- Frame 0x1C with parity flipped -> no event, one-cycle err_parity pulse, err_count=1; a following good 0x1C frame -> event 0x01C.
- Send 5 bits, then idle for TIMEOUT_CYCLES+10 -> err_frame pulses once, err_count=1; the next full frame 0x32 -> event 0x032, with no misalignment.
- FIFO_DEPTH+1 frames 0x10..0x18 without popping -> level=8, overflow=1, pops return 0x010..0x017; ovf_clr -> overflow=0. At full, assert ev_ready on the cycle a new push lands -> level stays 8 and overflow stays 0.
- Assert clr after 6 bits of a frame and after an E0 prefix -> all outputs return to reset values; the next 0x1C frame -> event 0x01C with ext=0.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared constants and event packing for the PS/2 receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] SCAN_EXT = 8'hE0;
    localparam logic [7:0] SCAN_BRK = 8'hF0;

    localparam int EV_W       = 10;
    localparam int EV_EXT     = 9;
    localparam int EV_BRK     = 8;
    localparam int EV_SCAN_HI = 7;
    localparam int EV_SCAN_LO = 0;

    function automatic logic [EV_W-1:0] make_event(input logic ext,
                                                   input logic brk,
                                                   input logic [7:0] scan);
        logic [EV_W-1:0] ev;
        ev                        = '0;
        ev[EV_EXT]                = ext;
        ev[EV_BRK]                = brk;
        ev[EV_SCAN_HI:EV_SCAN_LO] = scan;
        return ev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_frame_rx
// Description : Pin synchroniser and 11-bit PS/2 frame deserialiser with
//               start/parity/stop validation and mid-frame timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_rx #(
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_err_parity,
    output logic       o_err_frame
);

    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] c_to_last = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic [3:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic                   r_parity;
    logic [TW-1:0]          r_tocnt;
    logic                   r_byte_valid;
    logic                   r_err_parity;
    logic                   r_err_frame;

    logic w_strobe;
    logic w_data;

    assign w_strobe = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_data   = r_data_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_clk_sync   <= '0;
            r_data_sync  <= '0;
            r_clk_prev   <= 1'b0;
            r_bitcnt     <= 4'd0;
            r_shift      <= 8'd0;
            r_parity     <= 1'b0;
            r_tocnt      <= '0;
            r_byte_valid <= 1'b0;
            r_err_parity <= 1'b0;
            r_err_frame  <= 1'b0;
        end else begin
            r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev   <= r_clk_sync[SYNC_STAGES-1];
            r_byte_valid <= 1'b0;
            r_err_parity <= 1'b0;
            r_err_frame  <= 1'b0;

            if (w_strobe) begin
                r_tocnt <= '0;
                if (r_bitcnt == 4'd0) begin
                    // A high start bit is treated as line noise, giving resync.
                    if (!w_data) begin
                        r_bitcnt <= 4'd1;
                    end
                end else if (r_bitcnt <= 4'd8) begin
                    r_shift  <= {w_data, r_shift[7:1]};
                    r_bitcnt <= r_bitcnt + 4'd1;
                end else if (r_bitcnt == 4'd9) begin
                    r_parity <= w_data;
                    r_bitcnt <= 4'd10;
                end else begin
                    r_bitcnt <= 4'd0;
                    if (w_data && ((^r_shift) ^ r_parity)) begin
                        r_byte_valid <= 1'b1;
                    end else begin
                        r_err_parity <= 1'b1;
                    end
                end
            end else if (r_bitcnt != 4'd0) begin
                if (r_tocnt == c_to_last) begin
                    r_bitcnt    <= 4'd0;
                    r_tocnt     <= '0;
                    r_err_frame <= 1'b1;
                end else begin
                    r_tocnt <= r_tocnt + 1'b1;
                end
            end
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_shift;
    assign o_err_parity = r_err_parity;
    assign o_err_frame  = r_err_frame;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_events.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_events
// Description : PS/2 keyboard receiver: E0/F0 prefix folding, event FIFO
//               with valid/ready pop port, overflow and error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_events
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [EV_W-1:0]             ev_data,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    input  logic                        ovf_clr,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic [7:0]                  err_count
);

    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam int            LW      = PW + 1;
    localparam logic [LW-1:0] c_depth = LW'(FIFO_DEPTH);

    logic            w_byte_valid;
    logic [7:0]      w_byte;
    logic            w_err_parity;
    logic            w_err_frame;

    logic            r_ext_pend;
    logic            r_brk_pend;
    logic [EV_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic            r_overflow;
    logic [7:0]      r_err_count;

    logic            w_is_prefix;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_accept;
    logic [EV_W-1:0] w_event;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk          (clk),
        .clr          (clr),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_err_parity (w_err_parity),
        .o_err_frame  (w_err_frame)
    );

    assign w_is_prefix = (w_byte == SCAN_EXT) || (w_byte == SCAN_BRK);
    assign w_push      = w_byte_valid && !w_is_prefix;
    assign w_pop       = ev_valid && ev_ready;
    assign w_full      = (r_level == c_depth);
    assign w_accept    = w_push && (!w_full || w_pop);
    assign w_event     = make_event(r_ext_pend, r_brk_pend, w_byte);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_err_frame) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_byte_valid) begin
            if (w_byte == SCAN_EXT) begin
                r_ext_pend <= 1'b1;
            end else if (w_byte == SCAN_BRK) begin
                r_brk_pend <= 1'b1;
            end else begin
                // Flags are consumed even when the event is dropped on overflow.
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= w_event;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_err_count <= 8'd0;
        end else if ((w_err_parity || w_err_frame) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign ev_valid   = (r_level != '0);
    assign ev_data    = r_mem[r_rptr];
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign err_parity = w_err_parity;
    assign err_frame  = w_err_frame;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire
